// File: rtl/reorderbuf_mc_if.sv
// Dispatch / finish / commit bundle between the out-of-order core and the reorder buffer.
// The master modport is the core side and the slave modport is the ROB.
interface reorderbuf_mc_if #(
    parameter int unsigned RRF_SEL   = 6,
    parameter int unsigned DP_WIDTH  = 2,
    parameter int unsigned CM_WIDTH  = 4,
    parameter int unsigned FIN_PORTS = 5,
    parameter int unsigned REG_SEL   = 5,
    parameter int unsigned ADDR_LEN  = 32,
    parameter int unsigned BHR_LEN   = 10
);
    localparam int unsigned CNUM_W = $clog2(CM_WIDTH) + 1;

    logic [DP_WIDTH-1:0]           dp_valid;
    logic [DP_WIDTH*ADDR_LEN-1:0]  dp_pc;
    logic [DP_WIDTH-1:0]           dp_store;
    logic [DP_WIDTH-1:0]           dp_isbranch;
    logic [DP_WIDTH-1:0]           dp_dstvalid;
    logic [DP_WIDTH*REG_SEL-1:0]   dp_dst;
    logic [DP_WIDTH*BHR_LEN-1:0]   dp_bhr;
    logic [RRF_SEL-1:0]            dp_ptr;
    logic                          dp_ready;

    logic [FIN_PORTS-1:0]          fin_valid;
    logic [FIN_PORTS*RRF_SEL-1:0]  fin_addr;
    logic                          fin_brcond;
    logic [ADDR_LEN-1:0]           fin_jmpaddr;

    logic                          prmiss;
    logic [RRF_SEL-1:0]            prmiss_addr;

    logic [CM_WIDTH-1:0]           commit_valid;
    logic [RRF_SEL-1:0]            comptr;
    logic [CNUM_W-1:0]             comnum;
    logic [CM_WIDTH-1:0]           arfwe;
    logic [CM_WIDTH*REG_SEL-1:0]   dstarf;
    logic                          stcommit;
    logic                          combranch;
    logic [ADDR_LEN-1:0]           pc_combranch;
    logic [BHR_LEN-1:0]            bhr_combranch;
    logic                          brcond_combranch;
    logic [ADDR_LEN-1:0]           jmpaddr_combranch;
    logic [RRF_SEL:0]              occupancy;

    modport master (
        output dp_valid, dp_pc, dp_store, dp_isbranch, dp_dstvalid, dp_dst, dp_bhr,
        output fin_valid, fin_addr, fin_brcond, fin_jmpaddr, prmiss, prmiss_addr,
        input  dp_ptr, dp_ready, commit_valid, comptr, comnum, arfwe, dstarf,
        input  stcommit, combranch, pc_combranch, bhr_combranch, brcond_combranch,
        input  jmpaddr_combranch, occupancy
    );

    modport slave (
        input  dp_valid, dp_pc, dp_store, dp_isbranch, dp_dstvalid, dp_dst, dp_bhr,
        input  fin_valid, fin_addr, fin_brcond, fin_jmpaddr, prmiss, prmiss_addr,
        output dp_ptr, dp_ready, commit_valid, comptr, comnum, arfwe, dstarf,
        output stcommit, combranch, pc_combranch, bhr_combranch, brcond_combranch,
        output jmpaddr_combranch, occupancy
    );
endinterface

// File: rtl/reorderbuf_mc.sv
// Multi-commit reorder buffer: DP_WIDTH-wide allocation, FIN_PORTS completion,
// in-order retirement of up to CM_WIDTH entries per cycle, and mispredict truncation.
module reorderbuf_mc #(
    parameter int unsigned RRF_SEL   = 6,
    parameter int unsigned DP_WIDTH  = 2,
    parameter int unsigned CM_WIDTH  = 4,
    parameter int unsigned FIN_PORTS = 5,
    parameter int unsigned REG_SEL   = 5,
    parameter int unsigned ADDR_LEN  = 32,
    parameter int unsigned BHR_LEN   = 10
) (
    input logic            clk,
    input logic            reset_n,
    reorderbuf_mc_if.slave bus
);
    localparam int unsigned DEPTH   = 1 << RRF_SEL;
    localparam int unsigned PW      = RRF_SEL + 1;
    localparam int unsigned CNW     = $clog2(CM_WIDTH) + 1;
    localparam int unsigned BR_PORT = FIN_PORTS - 1;

    // control state (reset)
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0]      r_finish;

    // payload (not reset)
    logic [DEPTH-1:0]      r_store;
    logic [DEPTH-1:0]      r_isbranch;
    logic [DEPTH-1:0]      r_dstvalid;
    logic [DEPTH-1:0]      r_brcond;
    logic [REG_SEL-1:0]    r_dst     [DEPTH];
    logic [ADDR_LEN-1:0]   r_pc      [DEPTH];
    logic [BHR_LEN-1:0]    r_bhr     [DEPTH];
    logic [ADDR_LEN-1:0]   r_jmpaddr [DEPTH];

    logic [PW-1:0]         w_occ;
    logic [PW-1:0]         w_free;
    logic                  w_dp_ready;
    logic                  w_dp_fire;
    logic [PW-1:0]         w_dp_cnt;
    logic [RRF_SEL-1:0]    w_dp_idx  [DP_WIDTH];
    logic [RRF_SEL-1:0]    w_fin_idx [FIN_PORTS];
    logic [RRF_SEL-1:0]    w_cm_idx  [CM_WIDTH];
    logic [CM_WIDTH-1:0]   w_cm_valid;
    logic [CNW-1:0]        w_cm_num;
    logic [CM_WIDTH-1:0]   w_arfwe;
    logic [CM_WIDTH*REG_SEL-1:0] w_dstarf;
    logic                  w_chain;
    logic                  w_st;
    logic                  w_br;
    logic [RRF_SEL-1:0]    w_br_idx;
    logic [PW-1:0]         w_keep;
    logic [PW-1:0]         w_flush_tail;
    logic [RRF_SEL-1:0]    w_off [DEPTH];
    logic [DEPTH-1:0]      w_kill;

    assign w_occ      = r_tail - r_head;
    assign w_free     = PW'(DEPTH) - w_occ;
    assign w_dp_ready = (w_free >= PW'(DP_WIDTH));
    assign w_dp_fire  = w_dp_ready & ~bus.prmiss;

    // slot indices for dispatch, finish and commit
    always_comb begin
        w_dp_cnt = '0;
        for (int unsigned i = 0; i < DP_WIDTH; i++) begin
            w_dp_idx[i] = r_tail[RRF_SEL-1:0] + RRF_SEL'(i);
            w_dp_cnt    = w_dp_cnt + PW'(bus.dp_valid[i]);
        end
        for (int unsigned p = 0; p < FIN_PORTS; p++) begin
            w_fin_idx[p] = bus.fin_addr[p*RRF_SEL +: RRF_SEL];
        end
        for (int unsigned k = 0; k < CM_WIDTH; k++) begin
            w_cm_idx[k] = r_head[RRF_SEL-1:0] + RRF_SEL'(k);
        end
    end

    // commit group: in-order prefix of finished entries, closed by the first store or branch
    always_comb begin
        w_cm_valid = '0;
        w_cm_num   = '0;
        w_arfwe    = '0;
        w_dstarf   = '0;
        w_st       = 1'b0;
        w_br       = 1'b0;
        w_br_idx   = '0;
        w_chain    = ~bus.prmiss;
        for (int unsigned k = 0; k < CM_WIDTH; k++) begin
            if (w_chain && (PW'(k) < w_occ) && r_valid[w_cm_idx[k]] && r_finish[w_cm_idx[k]]) begin
                w_cm_valid[k] = 1'b1;
                w_cm_num      = w_cm_num + CNW'(1);
                w_arfwe[k]    = r_dstvalid[w_cm_idx[k]];
                w_dstarf[k*REG_SEL +: REG_SEL] = r_dst[w_cm_idx[k]];
                if (r_store[w_cm_idx[k]]) w_st = 1'b1;
                if (r_isbranch[w_cm_idx[k]]) begin
                    w_br     = 1'b1;
                    w_br_idx = w_cm_idx[k];
                end
                w_chain = ~(r_store[w_cm_idx[k]] | r_isbranch[w_cm_idx[k]]);
            end else begin
                w_chain = 1'b0;
            end
        end
    end

    // flush keeps head..prmiss_addr and kills everything younger
    always_comb begin
        w_keep       = PW'(RRF_SEL'(bus.prmiss_addr - r_head[RRF_SEL-1:0])) + PW'(1);
        w_flush_tail = r_head + w_keep;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            w_off[e]  = RRF_SEL'(e) - r_head[RRF_SEL-1:0];
            w_kill[e] = (PW'(w_off[e]) >= w_keep) && (PW'(w_off[e]) < w_occ);
        end
    end

    // later assignments override earlier ones: dispatch beats a stale finish
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_valid  <= '0;
            r_finish <= '0;
        end else begin
            for (int unsigned p = 0; p < FIN_PORTS; p++) begin
                if (bus.fin_valid[p] && r_valid[w_fin_idx[p]]) r_finish[w_fin_idx[p]] <= 1'b1;
            end
            for (int unsigned k = 0; k < CM_WIDTH; k++) begin
                if (w_cm_valid[k]) r_valid[w_cm_idx[k]] <= 1'b0;
            end
            r_head <= r_head + PW'(w_cm_num);
            if (bus.prmiss) begin
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    if (w_kill[e]) r_valid[e] <= 1'b0;
                end
                r_tail <= w_flush_tail;
            end else if (w_dp_fire) begin
                for (int unsigned i = 0; i < DP_WIDTH; i++) begin
                    if (bus.dp_valid[i]) begin
                        r_valid[w_dp_idx[i]]  <= 1'b1;
                        r_finish[w_dp_idx[i]] <= 1'b0;
                    end
                end
                r_tail <= r_tail + w_dp_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.fin_valid[BR_PORT] && r_valid[w_fin_idx[BR_PORT]]) begin
            r_brcond[w_fin_idx[BR_PORT]]  <= bus.fin_brcond;
            r_jmpaddr[w_fin_idx[BR_PORT]] <= bus.fin_jmpaddr;
        end
        if (w_dp_fire) begin
            for (int unsigned i = 0; i < DP_WIDTH; i++) begin
                if (bus.dp_valid[i]) begin
                    r_store[w_dp_idx[i]]    <= bus.dp_store[i];
                    r_isbranch[w_dp_idx[i]] <= bus.dp_isbranch[i];
                    r_dstvalid[w_dp_idx[i]] <= bus.dp_dstvalid[i];
                    r_dst[w_dp_idx[i]]      <= bus.dp_dst[i*REG_SEL +: REG_SEL];
                    r_pc[w_dp_idx[i]]       <= bus.dp_pc[i*ADDR_LEN +: ADDR_LEN];
                    r_bhr[w_dp_idx[i]]      <= bus.dp_bhr[i*BHR_LEN +: BHR_LEN];
                end
            end
        end
    end

    assign bus.dp_ptr            = r_tail[RRF_SEL-1:0];
    assign bus.dp_ready          = w_dp_ready;
    assign bus.occupancy         = w_occ;
    assign bus.comptr            = r_head[RRF_SEL-1:0];
    assign bus.commit_valid      = w_cm_valid;
    assign bus.comnum            = w_cm_num;
    assign bus.arfwe             = w_arfwe;
    assign bus.dstarf            = w_dstarf;
    assign bus.stcommit          = w_st;
    assign bus.combranch         = w_br;
    assign bus.pc_combranch      = w_br ? r_pc[w_br_idx]      : '0;
    assign bus.bhr_combranch     = w_br ? r_bhr[w_br_idx]     : '0;
    assign bus.brcond_combranch  = w_br ? r_brcond[w_br_idx]  : 1'b0;
    assign bus.jmpaddr_combranch = w_br ? r_jmpaddr[w_br_idx] : '0;
endmodule

// File: tb/tb_reorderbuf_mc.sv
// Scoreboard bench for reorderbuf_mc: retirements are checked by a monitor against a
// queue of expected entries; directed checks cover pointers, occupancy, flush and reset.
module tb_reorderbuf_mc;
    logic clk;
    logic reset_n;

    reorderbuf_mc_if bus();

    reorderbuf_mc dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct packed {
        logic [5:0] tag;
        logic       dv;
        logic [4:0] dst;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lap   = 0;
    logic [31:0] m_pc  [64];
    logic [9:0]  m_bhr [64];
    logic        m_dv  [64];
    logic [4:0]  m_dst [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.dp_valid   = '0;
        bus.fin_valid  = '0;
        bus.prmiss     = 1'b0;
        bus.fin_brcond = 1'b0;
    endtask

    task automatic dispatch2(input int t0, input logic [1:0] st, input logic [1:0] br);
        for (int i = 0; i < 2; i++) begin
            int t;
            t = (t0 + i) % 64;
            m_pc[t]  = 32'h0001_0000 + 32'(lap << 12) + 32'(t * 4);
            m_bhr[t] = 10'(t * 7 + lap);
            m_dv[t]  = ((t % 3) != 0);
            m_dst[t] = 5'(t ^ 21);
            bus.dp_pc[i*32 +: 32]  = m_pc[t];
            bus.dp_bhr[i*10 +: 10] = m_bhr[t];
            bus.dp_dst[i*5 +: 5]   = m_dst[t];
            bus.dp_dstvalid[i]     = m_dv[t];
            bus.dp_store[i]        = st[i];
            bus.dp_isbranch[i]     = br[i];
        end
        bus.dp_valid = 2'b11;
    endtask

    task automatic fin(input int port, input int tag);
        bus.fin_valid[port]        = 1'b1;
        bus.fin_addr[port*6 +: 6]  = 6'(tag);
    endtask

    task automatic push(input int tag);
        exp_t e;
        e.tag = 6'(tag);
        e.dv  = m_dv[tag];
        e.dst = m_dst[tag];
        sb.push_back(e);
    endtask

    // monitor: every retiring slot must match the oldest expected entry
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                for (int k = 0; k < 4; k++) begin
                    if (bus.commit_valid[k]) begin
                        if (sb.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL sb_empty: slot %0d retired tag %0d with nothing expected", k, bus.comptr + 6'(k));
                        end else begin
                            e = sb.pop_front();
                            chk("cm_tag",   64'(6'(bus.comptr + 6'(k))), 64'(e.tag));
                            chk("cm_arfwe", 64'(bus.arfwe[k]),           64'(e.dv));
                            chk("cm_dst",   64'(bus.dstarf[k*5 +: 5]),   64'(e.dst));
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        reset_n          = 1'b0;
        bus.dp_valid     = '0;
        bus.dp_pc        = '0;
        bus.dp_store     = '0;
        bus.dp_isbranch  = '0;
        bus.dp_dstvalid  = '0;
        bus.dp_dst       = '0;
        bus.dp_bhr       = '0;
        bus.fin_valid    = '0;
        bus.fin_addr     = '0;
        bus.fin_brcond   = 1'b0;
        bus.fin_jmpaddr  = '0;
        bus.prmiss       = 1'b0;
        bus.prmiss_addr  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_occ",    64'(bus.occupancy),    64'd0);
        chk("rst_ready",  64'(bus.dp_ready),     64'd1);
        chk("rst_commit", 64'(bus.commit_valid), 64'd0);
        chk("rst_comptr", 64'(bus.comptr),       64'd0);
        reset_n = 1'b1;

        // fill: tag 5 is a store, tag 9 a branch
        for (int c = 0; c < 31; c++) begin
            dispatch2(2 * c, (2 * c == 4) ? 2'b10 : 2'b00, (2 * c == 8) ? 2'b10 : 2'b00);
            tick();
        end
        @(negedge clk);
        chk("fill_occ62",   64'(bus.occupancy), 64'd62);
        chk("fill_ready62", 64'(bus.dp_ready),  64'd1);
        dispatch2(62, 2'b00, 2'b00);
        tick();
        @(negedge clk);
        chk("full_occ",   64'(bus.occupancy), 64'd64);
        chk("full_ready", 64'(bus.dp_ready),  64'd0);
        chk("full_ptr",   64'(bus.dp_ptr),    64'd0);
        bus.dp_valid = 2'b11;
        tick();
        @(negedge clk);
        chk("full_drop_occ", 64'(bus.occupancy), 64'd64);

        // four plain entries retire together
        for (int p = 0; p < 4; p++) begin fin(p, p); push(p); end
        tick();
        @(negedge clk);
        chk("c4_valid",  64'(bus.commit_valid), 64'hF);
        chk("c4_num",    64'(bus.comnum),       64'd4);
        chk("c4_comptr", 64'(bus.comptr),       64'd0);
        chk("c4_arfwe",  64'(bus.arfwe),        64'h6);
        tick();
        @(negedge clk);
        chk("c4_comptr_after", 64'(bus.comptr),    64'd4);
        chk("c4_occ_after",    64'(bus.occupancy), 64'd60);

        // store at tag 5 closes the group
        for (int p = 0; p < 4; p++) begin fin(p, 4 + p); push(4 + p); end
        tick();
        @(negedge clk);
        chk("st_valid",  64'(bus.commit_valid), 64'h3);
        chk("st_commit", 64'(bus.stcommit),     64'd1);
        chk("st_num",    64'(bus.comnum),       64'd2);
        tick();
        @(negedge clk);
        chk("st2_valid",  64'(bus.commit_valid), 64'h3);
        chk("st2_commit", 64'(bus.stcommit),     64'd0);
        chk("st2_comptr", 64'(bus.comptr),       64'd6);

        // branch at tag 9 resolved through the branch port
        fin(0, 8);
        fin(4, 9);
        bus.fin_brcond  = 1'b1;
        bus.fin_jmpaddr = 32'hDEAD_BEEF;
        push(8);
        push(9);
        tick();
        @(negedge clk);
        chk("br_valid",  64'(bus.commit_valid),      64'h3);
        chk("br_flag",   64'(bus.combranch),         64'd1);
        chk("br_pc",     64'(bus.pc_combranch),      64'h0001_0024);
        chk("br_bhr",    64'(bus.bhr_combranch),     64'd63);
        chk("br_cond",   64'(bus.brcond_combranch),  64'd1);
        chk("br_jmp",    64'(bus.jmpaddr_combranch), 64'hDEAD_BEEF);
        tick();

        // drain 10..59, then wrap across 63->0
        for (int b = 10; b < 60; b += 4) begin
            for (int p = 0; p < 4; p++) begin
                if (b + p < 60) begin fin(p, b + p); push(b + p); end
            end
            tick();
        end
        tick();
        tick();
        @(negedge clk);
        chk("drain_comptr", 64'(bus.comptr),    64'd60);
        chk("drain_occ",    64'(bus.occupancy), 64'd4);
        lap = 1;
        dispatch2(0, 2'b00, 2'b00);
        tick();
        dispatch2(2, 2'b00, 2'b00);
        tick();
        for (int t = 60; t < 64; t++) push(t);
        push(0);
        push(1);
        fin(0, 0);
        fin(1, 1);
        tick();
        @(negedge clk);
        chk("wrap_wait", 64'(bus.commit_valid), 64'h0);
        for (int p = 0; p < 4; p++) fin(p, 60 + p);
        tick();
        @(negedge clk);
        chk("wrap_valid",  64'(bus.commit_valid), 64'hF);
        chk("wrap_comptr", 64'(bus.comptr),       64'd60);
        tick();
        @(negedge clk);
        chk("wrap_comptr0", 64'(bus.comptr),       64'd0);
        chk("wrap_valid2",  64'(bus.commit_valid), 64'h3);
        tick();

        // mispredict: head 10, tail 20, branch at 12
        for (int t = 4; t < 20; t += 2) begin
            dispatch2(t, 2'b00, (t == 12) ? 2'b01 : 2'b00);
            tick();
        end
        for (int p = 0; p < 4; p++) begin fin(p, 2 + p); push(2 + p); end
        tick();
        for (int p = 0; p < 4; p++) begin fin(p, 6 + p); push(6 + p); end
        tick();
        tick();
        @(negedge clk);
        chk("pm_comptr", 64'(bus.comptr),    64'd10);
        chk("pm_occ",    64'(bus.occupancy), 64'd10);
        fin(0, 10);
        push(10);
        tick();
        bus.prmiss      = 1'b1;
        bus.prmiss_addr = 6'd12;
        bus.dp_valid    = 2'b11;
        @(negedge clk);
        chk("pm_nocommit", 64'(bus.commit_valid), 64'h0);
        tick();
        fin(0, 11);
        fin(1, 15);
        fin(4, 12);
        bus.fin_brcond  = 1'b0;
        bus.fin_jmpaddr = 32'h0000_1234;
        push(11);
        push(12);
        @(negedge clk);
        chk("pm_occ3",   64'(bus.occupancy),    64'd3);
        chk("pm_ptr",    64'(bus.dp_ptr),       64'd13);
        chk("pm_c10",    64'(bus.commit_valid), 64'h1);
        tick();
        @(negedge clk);
        chk("pm_br_valid", 64'(bus.commit_valid),      64'h3);
        chk("pm_br_flag",  64'(bus.combranch),         64'd1);
        chk("pm_br_cond",  64'(bus.brcond_combranch),  64'd0);
        chk("pm_br_jmp",   64'(bus.jmpaddr_combranch), 64'h1234);
        chk("pm_br_pc",    64'(bus.pc_combranch),      64'h0001_1030);
        chk("pm_br_bhr",   64'(bus.bhr_combranch),     64'd85);
        tick();
        @(negedge clk);
        chk("pm_empty_occ",    64'(bus.occupancy),    64'd0);
        chk("pm_late_fin_15",  64'(bus.commit_valid), 64'h0);

        // asynchronous reset in the middle of a retiring burst
        dispatch2(13, 2'b00, 2'b00);
        tick();
        dispatch2(15, 2'b00, 2'b00);
        tick();
        for (int p = 0; p < 4; p++) begin fin(p, 13 + p); push(13 + p); end
        tick();
        @(negedge clk);
        chk("ar_pre_valid", 64'(bus.commit_valid), 64'hF);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_commit", 64'(bus.commit_valid), 64'h0);
        chk("ar_occ",    64'(bus.occupancy),    64'd0);
        chk("ar_comnum", 64'(bus.comnum),       64'd0);
        chk("ar_ready",  64'(bus.dp_ready),     64'd1);
        chk("ar_comptr", 64'(bus.comptr),       64'd0);
        chk("ar_ptr",    64'(bus.dp_ptr),       64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        chk("post_occ",    64'(bus.occupancy),    64'd0);
        chk("post_commit", 64'(bus.commit_valid), 64'h0);
        chk("sb_drained",  64'(sb.size()),        64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
